// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its pending scoreboard.
package regfile_pkg;
  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_NUM_READ = 2;
  localparam int ZERO_REG         = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: reserve sets, write clears, reserve wins on the same index.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_READ = REGFILE_NUM_READ
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr_en,
  input  logic [ADDR_W-1:0]                  clr_idx,
  input  logic                               set_en,
  input  logic [ADDR_W-1:0]                  set_idx,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]    rd_idx,
  output logic [NUM_READ-1:0]                busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pend;

  // Set is applied after clear so a new producer supersedes a completing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (clr_en && clr_idx != ZERO_IDX) pend[clr_idx] <= 1'b0;
      if (set_en && set_idx != ZERO_IDX) pend[set_idx] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    assign busy[i] = (rd_idx[i] != ZERO_IDX) && pend[rd_idx[i]];
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, async clear and pending scoreboard.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_READ = REGFILE_NUM_READ
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadRegister,
  output logic [NUM_READ*DATA_W-1:0]   ReadData,
  output logic [NUM_READ-1:0]          ReadBusy,
  input  logic                         WriteEnable,
  input  logic [ADDR_W-1:0]            WriteRegister,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic                         ReserveEnable,
  input  logic [ADDR_W-1:0]            ReserveRegister
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NUM_READ-1:0][ADDR_W-1:0] rd_idx;
  logic [NUM_READ-1:0][DATA_W-1:0] rd_data;
  logic [NUM_READ-1:0]             sb_busy;
  logic [NUM_READ-1:0]             rd_busy;
  logic [DATA_W-1:0]               mem [DEPTH];

  assign rd_idx   = ReadRegister;
  assign ReadData = rd_data;
  assign ReadBusy = rd_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (WriteEnable && WriteRegister != ZERO_IDX) begin
      mem[WriteRegister] <= WriteData;
    end
  end

  reg_scoreboard #(.ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_en  (WriteEnable),
    .clr_idx (WriteRegister),
    .set_en  (ReserveEnable),
    .set_idx (ReserveRegister),
    .rd_idx  (rd_idx),
    .busy    (sb_busy)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic hit;
`ifdef REG_FILE_BYPASS_EN
    assign hit = WriteEnable && (WriteRegister != ZERO_IDX) && (rd_idx[i] == WriteRegister);
`else
    assign hit = 1'b0;
`endif
    // Zero register is forced here so a stray array value can never leak out.
    assign rd_data[i] = (rd_idx[i] == ZERO_IDX) ? '0 :
                        hit                     ? WriteData : mem[rd_idx[i]];
    assign rd_busy[i] = hit ? 1'b0 : sb_busy[i];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default-sized instance and a 4-port 64-bit instance,
// checked every cycle against an array model plus hand-computed literals.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // instance A: defaults (32-bit, 32 regs, 2 ports)
  logic [1:0][4:0]  a_rr;
  logic [1:0][31:0] a_rd;
  logic [1:0]       a_busy;
  logic             a_we, a_re;
  logic [4:0]       a_wr, a_rs;
  logic [31:0]      a_wd;

  // instance B: 64-bit, 16 regs, 4 ports
  logic [3:0][3:0]  b_rr;
  logic [3:0][63:0] b_rd;
  logic [3:0]       b_busy;
  logic             b_we, b_re;
  logic [3:0]       b_wr, b_rs;
  logic [63:0]      b_wd;

  reg_file_mp dut_a (
    .clk(clk), .rst_n(rst_n), .ReadRegister(a_rr), .ReadData(a_rd), .ReadBusy(a_busy),
    .WriteEnable(a_we), .WriteRegister(a_wr), .WriteData(a_wd),
    .ReserveEnable(a_re), .ReserveRegister(a_rs)
  );

  reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_READ(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ReadRegister(b_rr), .ReadData(b_rd), .ReadBusy(b_busy),
    .WriteEnable(b_we), .WriteRegister(b_wr), .WriteData(b_wd),
    .ReserveEnable(b_re), .ReserveRegister(b_rs)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: a plain array of words and a set of pending indices
  logic [31:0] mem_a [32];
  bit          pend_a [32];
  logic [63:0] mem_b [16];
  bit          pend_b [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin mem_a[k] = '0; pend_a[k] = 0; end
      for (int k = 0; k < 16; k++) begin mem_b[k] = '0; pend_b[k] = 0; end
    end else begin
      if (a_we && a_wr != 0) begin mem_a[a_wr] = a_wd; pend_a[a_wr] = 0; end
      if (a_re && a_rs != 0) pend_a[a_rs] = 1;
      if (b_we && b_wr != 0) begin mem_b[b_wr] = b_wd; pend_b[b_wr] = 0; end
      if (b_re && b_rs != 0) pend_b[b_rs] = 1;
    end
  end

  function automatic logic [31:0] exp_a_data(input logic [4:0] idx);
    if (idx == 0) return '0;
    if (BYP && a_we && a_wr == idx) return a_wd;
    return mem_a[idx];
  endfunction

  function automatic logic exp_a_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    if (BYP && a_we && a_wr == idx) return 1'b0;
    return pend_a[idx];
  endfunction

  function automatic logic [63:0] exp_b_data(input logic [3:0] idx);
    if (idx == 0) return '0;
    if (BYP && b_we && b_wr == idx) return b_wd;
    return mem_b[idx];
  endfunction

  function automatic logic exp_b_busy(input logic [3:0] idx);
    if (idx == 0) return 1'b0;
    if (BYP && b_we && b_wr == idx) return 1'b0;
    return pend_b[idx];
  endfunction

  // every-cycle compare, away from the rising edge
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      check("cmp_a_data", 64'(a_rd[p]), 64'(exp_a_data(a_rr[p])));
      check("cmp_a_busy", 64'(a_busy[p]), 64'(exp_a_busy(a_rr[p])));
    end
    for (int p = 0; p < 4; p++) begin
      check("cmp_b_data", b_rd[p], exp_b_data(b_rr[p]));
      check("cmp_b_busy", 64'(b_busy[p]), 64'(exp_b_busy(b_rr[p])));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [4:0] idx, input logic [31:0] d);
    a_we = 1'b1; a_wr = idx; a_wd = d;
    tick();
    a_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_rr = '0; a_we = 0; a_re = 0; a_wr = '0; a_rs = '0; a_wd = '0;
    b_rr = '0; b_we = 0; b_re = 0; b_wr = '0; b_rs = '0; b_wd = '0;
    tick(); tick();
    check("reset_a_data", 64'(a_rd[0]), 64'h0);
    check("reset_a_busy", 64'(a_busy), 64'h0);
    rst_n = 1'b1;

    // preload, then pulse reset mid-cycle: clears at once
    a_rr[0] = 5'd7; a_rr[1] = 5'd4;
    wr_a(5'd7, 32'hCAFE_F00D);
    wr_a(5'd4, 32'h0000_0444);
    a_re = 1'b1; a_rs = 5'd4; tick(); a_re = 1'b0;
    b_we = 1'b1; b_wr = 4'd3; b_wd = 64'h3333; tick(); b_we = 1'b0;
    b_rr[0] = 4'd3;
    check("preload_r7", 64'(a_rd[0]), 64'hCAFE_F00D);
    check("preload_r4_busy", 64'(a_busy[1]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_r7", 64'(a_rd[0]), 64'h0);
    check("midreset_r4", 64'(a_rd[1]), 64'h0);
    check("midreset_busy", 64'(a_busy), 64'h0);
    check("midreset_b_r3", b_rd[0], 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // write r7, read on both ports
    a_rr[0] = 5'd7; a_rr[1] = 5'd7;
    wr_a(5'd7, 32'hDEAD_BEEF);
    check("r7_p0", 64'(a_rd[0]), 64'hDEAD_BEEF);
    check("r7_p1", 64'(a_rd[1]), 64'hDEAD_BEEF);
    check("r7_busy", 64'(a_busy), 64'h0);

    // writes to r0 are dropped
    a_rr[0] = 5'd0;
    wr_a(5'd0, 32'h1234);
    check("r0_data", 64'(a_rd[0]), 64'h0);

    // reserve r5: not visible the same cycle, busy afterwards
    a_rr[0] = 5'd5;
    a_re = 1'b1; a_rs = 5'd5;
    #1 check("r5_same_cycle_busy", 64'(a_busy[0]), 64'h0);
    tick(); a_re = 1'b0;
    check("r5_busy", 64'(a_busy[0]), 64'h1);
    a_we = 1'b1; a_wr = 5'd5; a_wd = 32'h55;
    #1 check("r5_write_cycle_busy", 64'(a_busy[0]), BYP ? 64'h0 : 64'h1);
    tick(); a_we = 1'b0;
    check("r5_done_busy", 64'(a_busy[0]), 64'h0);
    check("r5_done_data", 64'(a_rd[0]), 64'h55);

    // reserve r0 is dropped
    a_rr[0] = 5'd0; a_re = 1'b1; a_rs = 5'd0; tick(); a_re = 1'b0;
    check("r0_busy", 64'(a_busy[0]), 64'h0);

    // same-cycle write + reserve to r9: data stored, still pending
    a_rr[0] = 5'd9;
    a_we = 1'b1; a_wr = 5'd9; a_wd = 32'hAA; a_re = 1'b1; a_rs = 5'd9;
    tick(); a_we = 1'b0; a_re = 1'b0;
    check("r9_data", 64'(a_rd[0]), 64'hAA);
    check("r9_busy", 64'(a_busy[0]), 64'h1);

    // write + reserve to different indices
    a_rr[0] = 5'd10; a_rr[1] = 5'd11;
    a_we = 1'b1; a_wr = 5'd10; a_wd = 32'h10; a_re = 1'b1; a_rs = 5'd11;
    tick(); a_we = 1'b0; a_re = 1'b0;
    check("r10_data", 64'(a_rd[0]), 64'h10);
    check("r10_busy", 64'(a_busy[0]), 64'h0);
    check("r11_busy", 64'(a_busy[1]), 64'h1);

    // same-cycle write while port 1 reads it
    wr_a(5'd3, 32'h11);
    a_rr[1] = 5'd3;
    a_we = 1'b1; a_wr = 5'd3; a_wd = 32'h77;
    #1 check("r3_bypass_cycle", 64'(a_rd[1]), BYP ? 64'h77 : 64'h11);
    tick(); a_we = 1'b0;
    check("r3_next_cycle", 64'(a_rd[1]), 64'h77);

    // wide instance: fill r1..r15, then four simultaneous reads
    for (int k = 1; k < 16; k++) begin
      b_we = 1'b1; b_wr = 4'(k); b_wd = 64'h0101_0101_0101_0101 * 64'(k);
      tick();
    end
    b_we = 1'b0;
    b_rr[0] = 4'd15; b_rr[1] = 4'd1; b_rr[2] = 4'd0; b_rr[3] = 4'd8;
    #1;
    check("b_r15", b_rd[0], 64'h0F0F_0F0F_0F0F_0F0F);
    check("b_r1",  b_rd[1], 64'h0101_0101_0101_0101);
    check("b_r0",  b_rd[2], 64'h0);
    check("b_r8",  b_rd[3], 64'h0808_0808_0808_0808);
    check("b_busy", 64'(b_busy), 64'h0);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
